// File: rtl/radix2_div.sv
// Radix-2 restoring divider, 32/32 signed or unsigned -> {remainder, quotient}.
// Latency: 33 cycles (nonzero divisor), 2 cycles (zero divisor or DIV_SMALL_FAST_EN early-out).
// Handshake: start_i held until ready_o; result held while start_i stays high; annul_i aborts.
module radix2_div (
  input  logic        clk,
  input  logic        resetn,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  typedef enum logic [1:0] {IDLE, BYZERO, ON, END} state_t;

  state_t      state;
  logic [5:0]  cnt;
  logic [64:0] work;      // {partial remainder[64:32], quotient[31:0]}
  logic [31:0] divisor;
  logic        neg_quot;
  logic        neg_rem;
`ifdef DIV_SMALL_FAST_EN
  logic        fast;
`endif

  logic [31:0] op1_mag;
  logic [31:0] op2_mag;
  logic [64:0] sh;
  logic [32:0] diff;
  logic [64:0] step;
  logic [31:0] q_fix;
  logic [31:0] r_fix;

  always_comb begin
    // Negating 0x80000000 yields 0x80000000, which reads correctly as 2^31 unsigned.
    op1_mag = (signed_div_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
    op2_mag = (signed_div_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;
    sh      = work << 1;
    diff    = sh[64:32] - {1'b0, divisor};
    step    = sh;
    if (sh[64:32] >= {1'b0, divisor})
      step = {diff, sh[31:1], 1'b1};
    q_fix   = neg_quot ? (~step[31:0] + 32'd1) : step[31:0];
    r_fix   = neg_rem  ? (~step[63:32] + 32'd1) : step[63:32];
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= IDLE;
      cnt      <= 6'd0;
      work     <= 65'd0;
      divisor  <= 32'd0;
      neg_quot <= 1'b0;
      neg_rem  <= 1'b0;
      ready_o  <= 1'b0;
      result_o <= 64'd0;
`ifdef DIV_SMALL_FAST_EN
      fast     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start_i && !annul_i) begin
            if (opdata2_i == 32'd0) begin
              state <= BYZERO;
`ifdef DIV_SMALL_FAST_EN
            end else if (op1_mag < op2_mag) begin
              // Early-out reuses the BYZERO hop so its latency matches the zero-divisor path.
              state <= BYZERO;
              fast  <= 1'b1;
              work  <= {1'b0, opdata1_i, 32'd0};
`endif
            end else begin
              state    <= ON;
              cnt      <= 6'd0;
              work     <= {33'd0, op1_mag};
              divisor  <= op2_mag;
              neg_quot <= signed_div_i & (opdata1_i[31] ^ opdata2_i[31]);
              neg_rem  <= signed_div_i & opdata1_i[31];
            end
          end
        end

        BYZERO: begin
          work <= 65'd0;
`ifdef DIV_SMALL_FAST_EN
          fast <= 1'b0;
`endif
          if (annul_i) begin
            state <= IDLE;
          end else begin
            state   <= END;
            ready_o <= 1'b1;
`ifdef DIV_SMALL_FAST_EN
            result_o <= fast ? {work[63:32], 32'd0} : 64'd0;
`else
            result_o <= 64'd0;
`endif
          end
        end

        ON: begin
          if (annul_i) begin
            state <= IDLE;
            cnt   <= 6'd0;
            work  <= 65'd0;
          end else begin
            work <= step;
            cnt  <= cnt + 6'd1;
            if (cnt == 6'd31) begin
              state    <= END;
              ready_o  <= 1'b1;
              result_o <= {r_fix, q_fix};
            end
          end
        end

        END: begin
          if (!start_i) begin
            state    <= IDLE;
            ready_o  <= 1'b0;
            result_o <= 64'd0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_radix2_div.sv
// Directed self-checking bench for radix2_div: vector table plus abort/reset sequences.
module tb_radix2_div;

`ifdef DIV_SMALL_FAST_EN
  localparam int SMALL_LAT = 2;
`else
  localparam int SMALL_LAT = 33;
`endif

  logic        clk = 1'b0;
  logic        resetn;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  radix2_div dut (
    .clk          (clk),
    .resetn       (resetn),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  typedef struct {
    logic        sg;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] res;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Returns cycles from start to first ready (-1 on timeout); expects start_i already high before E0.
  task automatic wait_ready(output int lat);
    int k;
    bit seen;
    k = 0;
    seen = 1'b0;
    while (!seen && k < 60) begin
      @(posedge clk);
      k++;
      #1;
      if (ready_o) seen = 1'b1;
    end
    lat = seen ? k + 1 : -1;
  endtask

  task automatic run_op(input logic sg, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] er, input int el, input string nm);
    int lat;
    @(negedge clk);
    signed_div_i = sg;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    @(posedge clk);
    @(negedge clk);
    // Operands must be ignored after the start cycle.
    signed_div_i = ~sg;
    opdata1_i    = ~a;
    opdata2_i    = 32'h0000_0003;
    wait_ready(lat);
    chk({nm, " latency"}, 64'(lat), 64'(el));
    chk({nm, " result"}, result_o, er);
    repeat (2) @(posedge clk);
    #1;
    chk({nm, " held"}, {ready_o, result_o}, {1'b1, er});
    @(negedge clk);
    start_i = 1'b0;
    @(posedge clk);
    #1;
    chk({nm, " drop"}, {ready_o, result_o}, 65'd0);
  endtask

  task automatic no_ready(input int n, input string nm);
    bit seen;
    seen = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
      if (ready_o) seen = 1'b1;
    end
    chk(nm, 64'(seen), 64'd0);
  endtask

  initial begin
    vecs[0]  = '{1'b0, 32'd100,        32'd7,          64'h00000002_0000000E, 33};
    vecs[1]  = '{1'b1, 32'hFFFFFFF9,   32'd2,          64'hFFFFFFFF_FFFFFFFD, 33};
    vecs[2]  = '{1'b0, 32'hFFFFFFF9,   32'd2,          64'h00000001_7FFFFFFC, 33};
    vecs[3]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   64'h00000000_80000000, 33};
    vecs[4]  = '{1'b0, 32'd5,          32'd0,          64'h0,                  2};
    vecs[5]  = '{1'b0, 32'd3,          32'd10,         64'h00000003_00000000, SMALL_LAT};
    vecs[6]  = '{1'b1, 32'd7,          32'hFFFFFFFE,   64'h00000001_FFFFFFFD, 33};
    vecs[7]  = '{1'b1, 32'hFFFFFFF9,   32'hFFFFFFFE,   64'hFFFFFFFF_00000003, 33};
    vecs[8]  = '{1'b0, 32'hFFFFFFFF,   32'd1,          64'h00000000_FFFFFFFF, 33};
    vecs[9]  = '{1'b1, 32'hFFFFFFFD,   32'd10,         64'hFFFFFFFD_00000000, SMALL_LAT};
    vecs[10] = '{1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF,   64'h00000000_00000001, 33};
    vecs[11] = '{1'b1, 32'd0,          32'd5,          64'h0,                  SMALL_LAT};

    resetn = 1'b0; signed_div_i = 1'b0; opdata1_i = 32'd0; opdata2_i = 32'd0;
    start_i = 1'b0; annul_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset state", {ready_o, result_o}, 65'd0);
    @(negedge clk);
    resetn = 1'b1;

    for (int i = 0; i < 12; i++)
      run_op(vecs[i].sg, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].lat, $sformatf("vec%0d", i));

    // Annul during ON at cycle 10.
    @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    annul_i = 1'b1; start_i = 1'b0;
    @(negedge clk);
    annul_i = 1'b0;
    no_ready(45, "annul on no ready");
    chk("annul on result", result_o, 64'd0);
    run_op(1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 33, "after annul");

    // Annul in BYZERO returns to IDLE.
    @(negedge clk);
    opdata1_i = 32'd5; opdata2_i = 32'd0; start_i = 1'b1;
    @(negedge clk);
    annul_i = 1'b1; start_i = 1'b0;
    @(negedge clk);
    annul_i = 1'b0;
    no_ready(5, "annul byzero no ready");

    // Annul ignored in END.
    @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = 32'd9; opdata2_i = 32'd3; start_i = 1'b1;
    repeat (40) @(posedge clk);
    @(negedge clk);
    annul_i = 1'b1;
    @(posedge clk);
    #1;
    chk("annul in end", {ready_o, result_o}, {1'b1, 64'h3});
    @(negedge clk);
    annul_i = 1'b0; start_i = 1'b0;
    @(posedge clk);
    #1;
    chk("end drop", {ready_o, result_o}, 65'd0);

    // Reset at cycle 20 of a divide.
    @(negedge clk);
    opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    resetn = 1'b0; start_i = 1'b0;
    @(posedge clk);
    #1;
    chk("reset mid op", {ready_o, result_o}, 65'd0);
    @(negedge clk);
    resetn = 1'b1;
    no_ready(40, "reset mid no ready");
    run_op(1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 33, "after reset");

    // Reset while holding a result in END.
    @(negedge clk);
    opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("end before reset", {ready_o, result_o}, {1'b1, 64'h00000002_0000000E});
    @(negedge clk);
    resetn = 1'b0;
    @(posedge clk);
    #1;
    chk("reset in end", {ready_o, result_o}, 65'd0);
    @(negedge clk);
    resetn = 1'b1; start_i = 1'b0;
    run_op(1'b0, 32'd3, 32'd10, 64'h00000003_00000000, SMALL_LAT, "post reset small");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
